// File: rtl/dualrail_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dualrail_pkg
//  Description : Shared types and constants for the dual-rail zero counter.
//                FSM state encoding, counting-mode selectors, lane status
//                encoding and a lane classification helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dualrail_pkg;

    // Counting-mode selectors for the MODE parameter
    localparam int MODE_ZEROES = 0;  // count false-rail (zero) bits
    localparam int MODE_ONES   = 1;  // count true-rail (one) bits

    // Handshake controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_RTZ   = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // Status of a single dual-rail lane
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,  // both rails low
        COMPLETE = 2'd1,  // exactly one rail high
        ILLEGAL  = 2'd2   // both rails high
    } lane_status_e;

    function automatic lane_status_e lane_status(input logic b1, input logic b0);
        lane_status_e s;
        if (b1 && b0) begin
            s = ILLEGAL;
        end else if (b1 || b0) begin
            s = COMPLETE;
        end else begin
            s = EMPTY;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dualrail_lane_decode.sv
`default_nettype none
// ============================================================================
//  Module      : dualrail_lane_decode
//  Description : Combinational classifier for a multi-lane dual-rail token.
//                Reports whether every lane holds a valid value, whether any
//                lane is illegal, and the number of lanes whose selected rail
//                (false rail for MODE_ZEROES, true rail for MODE_ONES) is high.
//  Ports       : bit1, bit0    - true / false rails, one bit per lane
//                all_complete  - every lane has exactly one rail high
//                any_illegal   - at least one lane has both rails high
//                k             - popcount of the selected rail
//  Revision    : 1.0  initial release
// ============================================================================
module dualrail_lane_decode
    import dualrail_pkg::*;
#(
    parameter int LANES = 1,
    parameter int MODE  = 0,
    localparam int KW   = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] bit1,
    input  logic [LANES-1:0] bit0,
    output logic             all_complete,
    output logic             any_illegal,
    output logic [KW-1:0]    k
);

    logic [LANES-1:0] w_complete;
    logic [LANES-1:0] w_illegal;
    logic [LANES-1:0] w_sel;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            lane_status_e w_st;
            assign w_st          = lane_status(bit1[i], bit0[i]);
            assign w_complete[i] = (w_st == COMPLETE);
            assign w_illegal[i]  = (w_st == ILLEGAL);
        end
    endgenerate

    assign w_sel        = (MODE == MODE_ZEROES) ? bit0 : bit1;
    assign all_complete = &w_complete;
    assign any_illegal  = |w_illegal;

    always_comb begin
        k = '0;
        for (int i = 0; i < LANES; i++) begin
            k = k + KW'(w_sel[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dualrail_zero_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dualrail_zero_counter
//  Description : Four-phase dual-rail token consumer that accumulates the
//                number of zero (or one) bits of each accepted token, wraps
//                the total at the configured modulus and emits a dual-rail
//                "count is zero" result per token.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                bit1, bit0        - input token rails (LANES wide)
//                in_ack            - acknowledge to the token producer
//                parity1, parity0  - result rails (updated count ==0 / !=0)
//                out_ack           - acknowledge from the result consumer
//                count             - accumulated count modulo the modulus
//                err               - sticky protocol error (illegal lane)
//  Revision    : 1.0  initial release
// ============================================================================
module dualrail_zero_counter
    import dualrail_pkg::*;
#(
    parameter int LANES = 1,
    parameter int MOD   = 2,
    parameter int MODE  = 0,
    localparam int CW   = ($clog2(MOD) < 1) ? 1 : $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] bit1,
    input  logic [LANES-1:0] bit0,
    output logic             in_ack,
    output logic             parity1,
    output logic             parity0,
    input  logic             out_ack,
    output logic [CW-1:0]    count,
    output logic             err
);

    localparam int KW = $clog2(LANES + 1);
    // Sum width holds (MOD-1) + LANES without overflow
    localparam int SW = CW + KW;

    state_e          r_state;
    logic [CW-1:0]   r_count;
    logic            r_in_ack;
    logic            r_parity1;
    logic            r_parity0;
    logic            r_err;

    logic            w_all_complete;
    logic            w_any_illegal;
    logic            w_any_active;
    logic [KW-1:0]   w_k;
    logic [SW-1:0]   w_sum;
    logic [SW-1:0]   w_mod;
    logic [CW-1:0]   w_next;

    dualrail_lane_decode #(
        .LANES (LANES),
        .MODE  (MODE)
    ) u_decode (
        .bit1         (bit1),
        .bit0         (bit0),
        .all_complete (w_all_complete),
        .any_illegal  (w_any_illegal),
        .k            (w_k)
    );

    // Return-to-zero of the input token requires every rail low
    assign w_any_active = |(bit1 | bit0);

    // k may exceed MOD, so a true modulo is needed rather than a single
    // conditional subtract
    assign w_sum  = SW'(r_count) + SW'(w_k);
    assign w_mod  = w_sum % SW'(MOD);
    assign w_next = w_mod[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_in_ack  <= 1'b0;
            r_parity1 <= 1'b0;
            r_parity0 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Illegal lane wins over a complete token
                    if (w_any_illegal) begin
                        r_state <= ST_ERROR;
                        r_err   <= 1'b1;
                    end else if (w_all_complete && !out_ack) begin
                        r_state   <= ST_EMIT;
                        r_count   <= w_next;
                        r_in_ack  <= 1'b1;
                        r_parity1 <= (w_next == '0);
                        r_parity0 <= (w_next != '0);
                    end
                end
                ST_EMIT: begin
                    if (out_ack) begin
                        r_state   <= ST_RTZ;
                        r_parity1 <= 1'b0;
                        r_parity0 <= 1'b0;
                    end
                end
                ST_RTZ: begin
                    if (!w_any_active && !out_ack) begin
                        r_state  <= ST_IDLE;
                        r_in_ack <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    // Sticky until reset
                    r_err     <= 1'b1;
                    r_in_ack  <= 1'b0;
                    r_parity1 <= 1'b0;
                    r_parity0 <= 1'b0;
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    assign in_ack  = r_in_ack;
    assign parity1 = r_parity1;
    assign parity0 = r_parity0;
    assign count   = r_count;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dualrail_zero_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dualrail_zero_counter
//  Description : Directed self-checking bench. Three instances share clk/rst:
//                  a: LANES=1 MOD=2 MODE=0
//                  b: LANES=4 MOD=3 MODE=0
//                  c: LANES=2 MOD=4 MODE=1
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dualrail_zero_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0] b1 [3];
    logic [3:0] b0 [3];
    logic [2:0] oa;

    logic       ia_a, p1_a, p0_a, er_a;
    logic       ia_b, p1_b, p0_b, er_b;
    logic       ia_c, p1_c, p0_c, er_c;
    logic [0:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] cnt_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dualrail_zero_counter #(.LANES(1), .MOD(2), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .bit1(b1[0][0:0]), .bit0(b0[0][0:0]),
        .in_ack(ia_a), .parity1(p1_a), .parity0(p0_a), .out_ack(oa[0]),
        .count(cnt_a), .err(er_a)
    );

    dualrail_zero_counter #(.LANES(4), .MOD(3), .MODE(0)) dut_b (
        .clk(clk), .rst(rst), .bit1(b1[1]), .bit0(b0[1]),
        .in_ack(ia_b), .parity1(p1_b), .parity0(p0_b), .out_ack(oa[1]),
        .count(cnt_b), .err(er_b)
    );

    dualrail_zero_counter #(.LANES(2), .MOD(4), .MODE(1)) dut_c (
        .clk(clk), .rst(rst), .bit1(b1[2][1:0]), .bit0(b0[2][1:0]),
        .in_ack(ia_c), .parity1(p1_c), .parity0(p0_c), .out_ack(oa[2]),
        .count(cnt_c), .err(er_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic [3:0] v1, input logic [3:0] v0);
        b1[i] = v1;
        b0[i] = v0;
    endtask

    task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks in_ack, parity1, parity0, count and err of instance i
    task automatic chk(input int i, input string tag, input logic e_ia, input logic e_p1,
                       input logic e_p0, input int e_cnt, input logic e_err);
        logic       o_ia, o_p1, o_p0, o_er;
        logic [7:0] o_cnt;
        case (i)
            0: begin o_ia = ia_a; o_p1 = p1_a; o_p0 = p0_a; o_er = er_a; o_cnt = 8'(cnt_a); end
            1: begin o_ia = ia_b; o_p1 = p1_b; o_p0 = p0_b; o_er = er_b; o_cnt = 8'(cnt_b); end
            default: begin o_ia = ia_c; o_p1 = p1_c; o_p0 = p0_c; o_er = er_c; o_cnt = 8'(cnt_c); end
        endcase
        chk1({tag, ".in_ack"},  8'(o_ia), 8'(e_ia));
        chk1({tag, ".parity1"}, 8'(o_p1), 8'(e_p1));
        chk1({tag, ".parity0"}, 8'(o_p0), 8'(e_p0));
        chk1({tag, ".count"},   o_cnt,    8'(e_cnt));
        chk1({tag, ".err"},     8'(o_er), 8'(e_err));
    endtask

    // Full four-phase handshake of one token on instance i
    task automatic hs(input int i, input string tag, input logic [3:0] v1, input logic [3:0] v0,
                      input logic e_p1, input logic e_p0, input int e_cnt);
        set_in(i, v1, v0);
        tick();
        chk(i, {tag, ".accept"}, 1'b1, e_p1, e_p0, e_cnt, 1'b0);
        set_in(i, ~v1, ~v0);  // changes during EMIT must be ignored
        tick();
        chk(i, {tag, ".hold"}, 1'b1, e_p1, e_p0, e_cnt, 1'b0);
        oa[i] = 1'b1;
        tick();
        chk(i, {tag, ".rtz"}, 1'b1, 1'b0, 1'b0, e_cnt, 1'b0);
        set_in(i, 4'h0, 4'h0);
        tick();
        oa[i] = 1'b0;
        tick();
        chk(i, {tag, ".idle"}, 1'b0, 1'b0, 1'b0, e_cnt, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            b1[i] = 4'h0;
            b0[i] = 4'h0;
        end
        oa = 3'b000;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) chk(i, "reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Instance a: tokens 0,0,1,0 -> 01,10,10,01 ; count 1,0,0,1
        hs(0, "a_t0", 4'h0, 4'h1, 1'b0, 1'b1, 1);
        hs(0, "a_t1", 4'h0, 4'h1, 1'b1, 1'b0, 0);
        hs(0, "a_t2", 4'h1, 4'h0, 1'b1, 1'b0, 0);
        hs(0, "a_t3", 4'h0, 4'h1, 1'b0, 1'b1, 1);

        // Instance b: reach count 2, then k=4 wraps to 0, then 0+4 -> 1
        hs(1, "b_t0", 4'b0011, 4'b1100, 1'b0, 1'b1, 2);
        hs(1, "b_k4", 4'b0000, 4'b1111, 1'b1, 1'b0, 0);
        hs(1, "b_k4b", 4'b0000, 4'b1111, 1'b0, 1'b1, 1);

        // Instance c: out_ack high in IDLE blocks acceptance
        oa[2] = 1'b1;
        set_in(2, 4'b0011, 4'b0000);
        tick();
        tick();
        chk(2, "c_oa_block", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        oa[2] = 1'b0;
        tick();
        chk(2, "c_oa_release", 1'b1, 1'b0, 1'b1, 2, 1'b0);
        oa[2] = 1'b1;
        tick();
        set_in(2, 4'h0, 4'h0);
        oa[2] = 1'b0;
        tick();
        chk(2, "c_idle0", 1'b0, 1'b0, 1'b0, 2, 1'b0);

        // Partial token: lane1 empty for 5 cycles, then completed
        set_in(2, 4'b0001, 4'b0000);
        repeat (5) tick();
        chk(2, "c_partial", 1'b0, 1'b0, 1'b0, 2, 1'b0);
        set_in(2, 4'b0001, 4'b0010);
        tick();
        chk(2, "c_complete", 1'b1, 1'b0, 1'b1, 3, 1'b0);

        // Inputs held high in RTZ with out_ack low: no re-acceptance
        oa[2] = 1'b1;
        tick();
        chk(2, "c_rtz", 1'b1, 1'b0, 1'b0, 3, 1'b0);
        oa[2] = 1'b0;
        repeat (3) tick();
        chk(2, "c_rtz_hold", 1'b1, 1'b0, 1'b0, 3, 1'b0);
        set_in(2, 4'h0, 4'h0);
        tick();
        chk(2, "c_rtz_exit", 1'b0, 1'b0, 1'b0, 3, 1'b0);

        // Wrap from MOD-1: 3 + 1 -> 0
        hs(2, "c_wrap", 4'b0001, 4'b0010, 1'b1, 1'b0, 0);

        // Illegal lane on instance a: sticky error, tokens ignored
        set_in(0, 4'h1, 4'h1);
        tick();
        chk(0, "a_illegal", 1'b0, 1'b0, 1'b0, 1, 1'b1);
        set_in(0, 4'h0, 4'h1);
        repeat (3) tick();
        chk(0, "a_err_sticky", 1'b0, 1'b0, 1'b0, 1, 1'b1);
        set_in(0, 4'h0, 4'h0);

        // Illegal lane beats otherwise-complete lanes on instance b
        set_in(1, 4'b0011, 4'b1110);
        tick();
        chk(1, "b_illegal_prio", 1'b0, 1'b0, 1'b0, 1, 1'b1);
        set_in(1, 4'h0, 4'h0);

        // Reset clears err and count everywhere
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(0, "a_rst_clear", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk(1, "b_rst_clear", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk(2, "c_rst_clear", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset during EMIT discards the token; held token is then accepted
        set_in(1, 4'b0111, 4'b1000);
        tick();
        chk(1, "b_pre_rst_emit", 1'b1, 1'b0, 1'b1, 1, 1'b0);
        rst = 1'b1;
        tick();
        chk(1, "b_rst_emit", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        tick();
        chk(1, "b_post_rst_accept", 1'b1, 1'b0, 1'b1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
